// File: rtl/digital_lock_ctrl_if.sv
// Front-panel bus between the key conditioning logic, the lock controller
// and the display/LED drivers.
//   key              : conditioned push-buttons, active-high (4-bit digit code)
//   lock_flag        : lock engaged
//   create_pwd_flag  : controller is taking a new password
//   confirm_pwd_flag : controller is taking the confirmation of a new password
//   enter_pwd_flag   : controller is taking an unlock attempt
//   error_flag       : controller is showing an error
//   lockout_flag     : controller is locked out after too many wrong attempts
//   attempts_left    : remaining tries before lockout
//   display_digits   : hex nibbles for the 7-seg driver, nibble 0 = rightmost
// master: the side that drives keys and consumes status.
// slave : the lock controller.
interface digital_lock_ctrl_if #(
  parameter int unsigned NUM_DISPLAYS = 6,
  parameter int unsigned MAX_ATTEMPTS = 3
) ();
  logic [3:0]                            key;
  logic                                  lock_flag;
  logic                                  create_pwd_flag;
  logic                                  confirm_pwd_flag;
  logic                                  enter_pwd_flag;
  logic                                  error_flag;
  logic                                  lockout_flag;
  logic [$clog2(MAX_ATTEMPTS+1)-1:0]     attempts_left;
  logic [NUM_DISPLAYS*4-1:0]             display_digits;

  modport master (
    output key,
    input  lock_flag, create_pwd_flag, confirm_pwd_flag, enter_pwd_flag,
    input  error_flag, lockout_flag, attempts_left, display_digits
  );

  modport slave (
    input  key,
    output lock_flag, create_pwd_flag, confirm_pwd_flag, enter_pwd_flag,
    output error_flag, lockout_flag, attempts_left, display_digits
  );
endinterface

// File: rtl/digital_lock_ctrl.sv
// Digital-lock controller: rising-edge key capture, create/confirm password
// flow, attempt counter with timed lockout and a per-state idle timeout.
// Ports:
//   clock : system clock
//   reset : asynchronous, active-high reset
//   bus   : digital_lock_ctrl_if.slave (key in; flags, attempts_left and
//           display_digits out, all registered)
module digital_lock_ctrl #(
  parameter int unsigned PASSWORD_LENGTH = 4,
  parameter int unsigned NUM_DISPLAYS    = 6,
  parameter int unsigned MAX_IDLE        = 500000000,
  parameter int unsigned MAX_ATTEMPTS    = 3,
  parameter int unsigned LOCKOUT_CYCLES  = 1500000000
) (
  input logic                clock,
  input logic                reset,
  digital_lock_ctrl_if.slave bus
);
  localparam int unsigned PW = PASSWORD_LENGTH * 4;
  localparam int unsigned DW = NUM_DISPLAYS * 4;
  localparam int unsigned AW = $clog2(MAX_ATTEMPTS + 1);
  localparam int unsigned CW = $clog2(PASSWORD_LENGTH + 1);
  localparam int unsigned IW = $clog2(MAX_IDLE + 1);
  localparam int unsigned LW = $clog2(LOCKOUT_CYCLES + 1);
  localparam logic [DW-1:0] ALL_E = {NUM_DISPLAYS{4'hE}};
  localparam logic [DW-1:0] ALL_F = {NUM_DISPLAYS{4'hF}};

  typedef enum logic [2:0] {
    S_UNLOCKED, S_CREATE, S_CONFIRM, S_LOCKED, S_ENTER, S_ERROR, S_LOCKOUT
  } state_t;

  state_t          r_state;
  logic            r_ret_locked;   // ERROR returns to LOCKED when set, else UNLOCKED
  logic [3:0]      r_prev_key;
  logic [CW-1:0]   r_cnt;
  logic [PW-1:0]   r_buf;
  logic [PW-1:0]   r_cand;
  logic [PW-1:0]   r_pwd;
  logic [IW-1:0]   r_idle;
  logic [LW-1:0]   r_lock;
  logic [AW-1:0]   r_attempts;
  logic [DW-1:0]   r_disp;
  logic [5:0]      r_flags;        // {lock, create, confirm, enter, error, lockout}

  logic            w_press;
  logic            w_last;
  logic            w_timeout;
  logic            w_in_enter;
  logic [PW-1:0]   w_buf_next;
  logic [PW-1:0]   w_disp_lo;

  // Flags are loaded together with the state they describe so they stay registered.
  function automatic logic [5:0] flags_of(state_t s, logic ret_locked);
    logic [5:0] f;
    f = '0;
    case (s)
      S_CREATE:  f[4] = 1'b1;
      S_CONFIRM: f[3] = 1'b1;
      S_LOCKED:  f[5] = 1'b1;
      S_ENTER:   f    = 6'b100100;
      S_ERROR:   f    = {ret_locked, 4'b0001, 1'b0};
      S_LOCKOUT: f    = 6'b100001;
      default:   f    = '0;
    endcase
    return f;
  endfunction

  assign w_press    = (bus.key != 4'h0) && (r_prev_key == 4'h0);
  assign w_last     = (r_cnt == CW'(PASSWORD_LENGTH - 1));
  // A press in the same cycle as the idle limit wins.
  assign w_timeout  = !w_press && (r_idle == IW'(MAX_IDLE - 1));
  assign w_in_enter = (r_state == S_ENTER);
  assign w_buf_next = (r_buf << 4) | PW'(bus.key);
  assign w_disp_lo  = (r_disp[PW-1:0] << 4) | PW'(bus.key);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= S_UNLOCKED;
      r_ret_locked <= 1'b0;
      r_prev_key   <= '0;
      r_cnt        <= '0;
      r_buf        <= '0;
      r_cand       <= '0;
      r_pwd        <= '0;
      r_idle       <= '0;
      r_lock       <= '0;
      r_attempts   <= AW'(MAX_ATTEMPTS);
      r_disp       <= '0;
      r_flags      <= '0;
    end else begin
      r_prev_key <= bus.key;
      case (r_state)
        S_UNLOCKED, S_LOCKED: begin
          r_disp <= '0;
          if (w_press) begin
            r_state <= (r_state == S_UNLOCKED) ? S_CREATE : S_ENTER;
            r_flags <= (r_state == S_UNLOCKED) ? flags_of(S_CREATE, 1'b0)
                                               : flags_of(S_ENTER, 1'b1);
          end
        end

        S_CREATE, S_CONFIRM, S_ENTER: begin
          if (w_press) begin
            r_idle <= '0;
            if (!w_last) begin
              r_cnt  <= r_cnt + 1'b1;
              r_buf  <= w_buf_next;
              r_disp <= DW'(w_disp_lo);
            end else begin
              // Last digit: w_buf_next is the full entry including this key.
              r_cnt <= '0;
              r_buf <= '0;
              case (r_state)
                S_CREATE: begin
                  r_cand  <= w_buf_next;
                  r_state <= S_CONFIRM;
                  r_flags <= flags_of(S_CONFIRM, 1'b0);
                  r_disp  <= '0;
                end
                S_CONFIRM: begin
                  r_cand <= '0;
                  if (w_buf_next == r_cand) begin
                    r_pwd   <= r_cand;
                    r_state <= S_LOCKED;
                    r_flags <= flags_of(S_LOCKED, 1'b0);
                    r_disp  <= '0;
                  end else begin
                    r_state      <= S_ERROR;
                    r_ret_locked <= 1'b0;
                    r_flags      <= flags_of(S_ERROR, 1'b0);
                    r_disp       <= ALL_E;
                  end
                end
                default: begin
                  if (w_buf_next == r_pwd) begin
                    r_pwd      <= '0;
                    r_attempts <= AW'(MAX_ATTEMPTS);
                    r_state    <= S_UNLOCKED;
                    r_flags    <= flags_of(S_UNLOCKED, 1'b0);
                    r_disp     <= '0;
                  end else if (r_attempts > AW'(1)) begin
                    r_attempts   <= r_attempts - 1'b1;
                    r_state      <= S_ERROR;
                    r_ret_locked <= 1'b1;
                    r_flags      <= flags_of(S_ERROR, 1'b1);
                    r_disp       <= ALL_E;
                  end else begin
                    r_attempts <= '0;
                    r_lock     <= '0;
                    r_state    <= S_LOCKOUT;
                    r_flags    <= flags_of(S_LOCKOUT, 1'b0);
                    r_disp     <= ALL_F;
                  end
                end
              endcase
            end
          end else if (w_timeout) begin
            r_idle       <= '0;
            r_cnt        <= '0;
            r_buf        <= '0;
            r_state      <= S_ERROR;
            r_ret_locked <= w_in_enter;
            r_flags      <= flags_of(S_ERROR, w_in_enter);
            r_disp       <= ALL_E;
            if (!w_in_enter) r_cand <= '0;
          end else begin
            r_idle <= r_idle + 1'b1;
          end
        end

        S_ERROR: begin
          if (w_press) begin
            r_state <= r_ret_locked ? S_LOCKED : S_UNLOCKED;
            r_flags <= r_ret_locked ? flags_of(S_LOCKED, 1'b1)
                                    : flags_of(S_UNLOCKED, 1'b0);
            r_disp  <= '0;
          end
        end

        S_LOCKOUT: begin
          if (r_lock == LW'(LOCKOUT_CYCLES - 1)) begin
            r_lock     <= '0;
            r_attempts <= AW'(MAX_ATTEMPTS);
            r_state    <= S_LOCKED;
            r_flags    <= flags_of(S_LOCKED, 1'b0);
            r_disp     <= '0;
          end else begin
            r_lock <= r_lock + 1'b1;
          end
        end

        default: begin
          r_state <= S_UNLOCKED;
          r_flags <= '0;
          r_disp  <= '0;
        end
      endcase
    end
  end

  assign bus.lock_flag        = r_flags[5];
  assign bus.create_pwd_flag  = r_flags[4];
  assign bus.confirm_pwd_flag = r_flags[3];
  assign bus.enter_pwd_flag   = r_flags[2];
  assign bus.error_flag       = r_flags[1];
  assign bus.lockout_flag     = r_flags[0];
  assign bus.attempts_left    = r_attempts;
  assign bus.display_digits   = r_disp;
endmodule

// File: tb/tb_digital_lock_ctrl.sv
// Self-checking bench for digital_lock_ctrl with small timing parameters.
module tb_digital_lock_ctrl;
  localparam logic [5:0] F_UNL = 6'b000000;
  localparam logic [5:0] F_CRE = 6'b010000;
  localparam logic [5:0] F_CON = 6'b001000;
  localparam logic [5:0] F_LCK = 6'b100000;
  localparam logic [5:0] F_ENT = 6'b100100;
  localparam logic [5:0] F_ERU = 6'b000010;
  localparam logic [5:0] F_ERL = 6'b100010;
  localparam logic [5:0] F_LKO = 6'b100001;

  typedef struct {
    logic [3:0]  key;
    logic [5:0]  fl;
    logic [1:0]  at;
    logic [23:0] dp;
  } vec_t;

  logic clock;
  logic reset;
  int   n_cmp;
  int   n_bad;
  vec_t tbl[$];

  digital_lock_ctrl_if #(.NUM_DISPLAYS(6), .MAX_ATTEMPTS(3)) bus_if ();

  digital_lock_ctrl #(
    .PASSWORD_LENGTH(4),
    .NUM_DISPLAYS(6),
    .MAX_IDLE(50),
    .MAX_ATTEMPTS(3),
    .LOCKOUT_CYCLES(20)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus_if)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [5:0] fe,
                       input logic [1:0] ae, input logic [23:0] de);
    logic [5:0] fa;
    fa = {bus_if.lock_flag, bus_if.create_pwd_flag, bus_if.confirm_pwd_flag,
          bus_if.enter_pwd_flag, bus_if.error_flag, bus_if.lockout_flag};
    n_cmp++;
    if ({fa, bus_if.attempts_left, bus_if.display_digits} !== {fe, ae, de}) begin
      n_bad++;
      $display("FAIL %s: got flags=%b att=%0d disp=%h, expected flags=%b att=%0d disp=%h",
               name, fa, bus_if.attempts_left, bus_if.display_digits, fe, ae, de);
    end
  endtask

  // One press: key high across one sampling edge, checked, then released.
  task automatic step(input string name, input logic [3:0] k, input logic [5:0] fe,
                      input logic [1:0] ae, input logic [23:0] de);
    @(negedge clock);
    bus_if.key = k;
    @(negedge clock);
    check(name, fe, ae, de);
    bus_if.key = 4'h0;
  endtask

  task automatic add(input logic [3:0] k, input logic [5:0] f,
                     input logic [1:0] a, input logic [23:0] d);
    vec_t v;
    v.key = k; v.fl = f; v.at = a; v.dp = d;
    tbl.push_back(v);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    bus_if.key = 4'h0;

    // happy path
    add(4'h1, F_CRE, 2'd3, 24'h0);
    add(4'h1, F_CRE, 2'd3, 24'h1);   add(4'h2, F_CRE, 2'd3, 24'h12);
    add(4'h4, F_CRE, 2'd3, 24'h124); add(4'h8, F_CON, 2'd3, 24'h0);
    add(4'h1, F_CON, 2'd3, 24'h1);   add(4'h2, F_CON, 2'd3, 24'h12);
    add(4'h4, F_CON, 2'd3, 24'h124); add(4'h8, F_LCK, 2'd3, 24'h0);
    add(4'h3, F_ENT, 2'd3, 24'h0);
    add(4'h1, F_ENT, 2'd3, 24'h1);   add(4'h2, F_ENT, 2'd3, 24'h12);
    add(4'h4, F_ENT, 2'd3, 24'h124); add(4'h8, F_UNL, 2'd3, 24'h0);
    // confirm mismatch
    add(4'h5, F_CRE, 2'd3, 24'h0);
    add(4'h1, F_CRE, 2'd3, 24'h1);   add(4'h2, F_CRE, 2'd3, 24'h12);
    add(4'h4, F_CRE, 2'd3, 24'h124); add(4'h8, F_CON, 2'd3, 24'h0);
    add(4'h1, F_CON, 2'd3, 24'h1);   add(4'h2, F_CON, 2'd3, 24'h12);
    add(4'h4, F_CON, 2'd3, 24'h124); add(4'h1, F_ERU, 2'd3, 24'hEEEEEE);
    add(4'h7, F_UNL, 2'd3, 24'h0);
    // password ABCD, then three wrong entries
    add(4'h1, F_CRE, 2'd3, 24'h0);
    add(4'hA, F_CRE, 2'd3, 24'hA);   add(4'hB, F_CRE, 2'd3, 24'hAB);
    add(4'hC, F_CRE, 2'd3, 24'hABC); add(4'hD, F_CON, 2'd3, 24'h0);
    add(4'hA, F_CON, 2'd3, 24'hA);   add(4'hB, F_CON, 2'd3, 24'hAB);
    add(4'hC, F_CON, 2'd3, 24'hABC); add(4'hD, F_LCK, 2'd3, 24'h0);
    add(4'h1, F_ENT, 2'd3, 24'h0);
    add(4'h1, F_ENT, 2'd3, 24'h1);   add(4'h1, F_ENT, 2'd3, 24'h11);
    add(4'h1, F_ENT, 2'd3, 24'h111); add(4'h1, F_ERL, 2'd2, 24'hEEEEEE);
    add(4'h1, F_LCK, 2'd2, 24'h0);   add(4'h1, F_ENT, 2'd2, 24'h0);
    add(4'h2, F_ENT, 2'd2, 24'h2);   add(4'h2, F_ENT, 2'd2, 24'h22);
    add(4'h2, F_ENT, 2'd2, 24'h222); add(4'h2, F_ERL, 2'd1, 24'hEEEEEE);
    add(4'h1, F_LCK, 2'd1, 24'h0);   add(4'h1, F_ENT, 2'd1, 24'h0);
    add(4'h3, F_ENT, 2'd1, 24'h3);   add(4'h3, F_ENT, 2'd1, 24'h33);
    add(4'h3, F_ENT, 2'd1, 24'h333); add(4'h3, F_LKO, 2'd0, 24'hFFFFFF);

    repeat (2) @(negedge clock);
    check("reset held", F_UNL, 2'd3, 24'h0);
    reset = 1'b0;
    @(negedge clock);
    check("after reset", F_UNL, 2'd3, 24'h0);

    for (int i = 0; i < tbl.size(); i++)
      step($sformatf("vec %0d", i), tbl[i].key, tbl[i].fl, tbl[i].at, tbl[i].dp);

    // lockout lasts exactly 20 cycles; presses inside it are ignored
    for (int i = 1; i < 20; i++) begin
      @(negedge clock);
      check($sformatf("lockout cyc %0d", i), F_LKO, 2'd0, 24'hFFFFFF);
      bus_if.key = ((i % 2) == 1 && i < 19) ? 4'h5 : 4'h0;
    end
    @(negedge clock);
    check("lockout end", F_LCK, 2'd3, 24'h0);

    // idle timeout in ENTER after two digits
    step("idle wake", 4'h1, F_ENT, 2'd3, 24'h0);
    step("idle d1", 4'hA, F_ENT, 2'd3, 24'hA);
    step("idle d2", 4'hB, F_ENT, 2'd3, 24'hAB);
    for (int i = 1; i < 50; i++) @(negedge clock);
    check("idle 49", F_ENT, 2'd3, 24'hAB);
    @(negedge clock);
    check("idle 50 timeout", F_ERL, 2'd3, 24'hEEEEEE);
    step("timeout return", 4'h1, F_LCK, 2'd3, 24'h0);

    // press on cycle 50 prevents the timeout
    step("race wake", 4'h1, F_ENT, 2'd3, 24'h0);
    step("race d1", 4'hA, F_ENT, 2'd3, 24'hA);
    for (int i = 1; i < 50; i++) @(negedge clock);
    bus_if.key = 4'hB;
    @(negedge clock);
    check("race press wins", F_ENT, 2'd3, 24'hAB);
    bus_if.key = 4'h0;
    step("race d3", 4'hC, F_ENT, 2'd3, 24'hABC);
    step("race unlock", 4'hD, F_UNL, 2'd3, 24'h0);

    // held key captures one digit only
    step("held wake", 4'h1, F_CRE, 2'd3, 24'h0);
    @(negedge clock);
    bus_if.key = 4'h2;
    repeat (10) @(negedge clock);
    check("held key", F_CRE, 2'd3, 24'h2);
    bus_if.key = 4'h0;
    step("held d2", 4'h3, F_CRE, 2'd3, 24'h23);
    step("held d3", 4'h4, F_CRE, 2'd3, 24'h234);
    step("held d4", 4'h5, F_CON, 2'd3, 24'h0);

    // asynchronous reset mid-CONFIRM
    step("pre-reset", 4'h2, F_CON, 2'd3, 24'h2);
    #2 reset = 1'b1;
    #1 check("async reset", F_UNL, 2'd3, 24'h0);
    @(negedge clock);
    reset = 1'b0;
    step("post-reset wake", 4'h1, F_CRE, 2'd3, 24'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
